// File: rtl/icache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_fill_ctrl
//   Instruction-fetch front end and miss handler for a direct-mapped, 8-line
//   instruction cache with 64-bit lines (4 x 16-bit words).
//
//   On a hit the addressed 16-bit word is returned from the cache line.
//   On a miss, fetch is stalled while the line is read from memory as two
//   32-bit beats (low beat first). The assembled line is then written into
//   the cache. Lines are never dirty, so there are no evictions.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   pc, fetch_re          IF-stage word address and fetch request
//   instr, stall          returned instruction word and pipeline hold
//   cache_addr/re/we      cache line address, read enable, write enable
//   cache_wdirty          dirty bit for writes (always 0)
//   cache_wr_data         assembled fill line
//   cache_hit/rd_data     cache lookup result and line data
//   mem_addr/re           memory beat address {line, beat} and read request
//   mem_rdy/rd_data       memory beat valid and data
//   miss_cnt              saturating count of completed fills
// ---------------------------------------------------------------------------
module icache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 64,
    parameter int BEAT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   pc,
    input  logic                fetch_re,
    output logic [15:0]         instr,
    output logic                stall,
    output logic [ADDR_W-3:0]   cache_addr,
    output logic                cache_re,
    output logic                cache_we,
    output logic                cache_wdirty,
    output logic [LINE_W-1:0]   cache_wr_data,
    input  logic                cache_hit,
    input  logic [LINE_W-1:0]   cache_rd_data,
    output logic [ADDR_W-2:0]   mem_addr,
    output logic                mem_re,
    input  logic                mem_rdy,
    input  logic [BEAT_W-1:0]   mem_rd_data,
    output logic [15:0]         miss_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_LO,
        S_MEM_HI,
        S_WRITE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-3:0]   miss_line_q, miss_line_d;
    logic [LINE_W-1:0]   buf_q, buf_d;
    logic [15:0]         miss_cnt_q, miss_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            miss_line_q <= '0;
            buf_q       <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            miss_line_q <= miss_line_d;
            buf_q       <= buf_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Word select: word 0 occupies bits [15:0] of the line.
    assign instr         = cache_rd_data[{pc[1:0], 4'b0000} +: 16];
    assign cache_wdirty  = 1'b0;
    assign cache_wr_data = buf_q;
    assign miss_cnt      = miss_cnt_q;

    always_comb begin
        state_d     = state_q;
        miss_line_d = miss_line_q;
        buf_d       = buf_q;
        miss_cnt_d  = miss_cnt_q;
        // Outside IDLE every address comes from the latched miss line, so
        // pc changes during a fill cannot disturb it.
        cache_addr  = miss_line_q;
        cache_re    = 1'b0;
        cache_we    = 1'b0;
        mem_addr    = {miss_line_q, 1'b0};
        mem_re      = 1'b0;
        stall       = 1'b1;

        case (state_q)
            S_IDLE: begin
                cache_addr = pc[ADDR_W-1:2];
                cache_re   = fetch_re;
                stall      = fetch_re & ~cache_hit;
                if (fetch_re && !cache_hit) begin
                    miss_line_d = pc[ADDR_W-1:2];
                    state_d     = S_MEM_LO;
                end
            end
            S_MEM_LO: begin
                mem_re = 1'b1;
                if (mem_rdy) begin
                    buf_d[BEAT_W-1:0] = mem_rd_data;
                    state_d           = S_MEM_HI;
                end
            end
            S_MEM_HI: begin
                mem_re   = 1'b1;
                mem_addr = {miss_line_q, 1'b1};
                if (mem_rdy) begin
                    buf_d[LINE_W-1:BEAT_W] = mem_rd_data;
                    state_d                = S_WRITE;
                end
            end
            S_WRITE: begin
                cache_we = 1'b1;
                if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_d = miss_cnt_q + 16'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Testbench for icache_fill_ctrl: cache and memory models around the DUT,
// directed fetch sequences, and a scoreboard monitor for beats, line writes
// and delivered instructions.
module tb_icache_fill_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic        fetch_re;
    logic [15:0] instr;
    logic        stall;
    logic [13:0] cache_addr;
    logic        cache_re;
    logic        cache_we;
    logic        cache_wdirty;
    logic [63:0] cache_wr_data;
    logic        cache_hit;
    logic [63:0] cache_rd_data;
    logic [14:0] mem_addr;
    logic        mem_re;
    logic        mem_rdy;
    logic [31:0] mem_rd_data;
    logic [15:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    icache_fill_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .fetch_re      (fetch_re),
        .instr         (instr),
        .stall         (stall),
        .cache_addr    (cache_addr),
        .cache_re      (cache_re),
        .cache_we      (cache_we),
        .cache_wdirty  (cache_wdirty),
        .cache_wr_data (cache_wr_data),
        .cache_hit     (cache_hit),
        .cache_rd_data (cache_rd_data),
        .mem_addr      (mem_addr),
        .mem_re        (mem_re),
        .mem_rdy       (mem_rdy),
        .mem_rd_data   (mem_rd_data),
        .miss_cnt      (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: every beat address has a distinct, recognisable word.
    function automatic logic [31:0] beat_data(input logic [14:0] a);
        return {1'b1, a, 1'b0, a ^ 15'h5A5A};
    endfunction

    function automatic logic [63:0] line_data(input logic [13:0] l);
        return {beat_data({l, 1'b1}), beat_data({l, 1'b0})};
    endfunction

    function automatic logic [15:0] word_of(input logic [15:0] a);
        logic [63:0] ln;
        ln = line_data(a[15:2]);
        return ln[{a[1:0], 4'b0000} +: 16];
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    // Direct-mapped cache model: index = line[2:0], tag = line[13:3].
    logic [10:0] tag_m   [8];
    logic        valid_m [8];
    logic [63:0] data_m  [8];

    always_comb begin
        cache_hit     = valid_m[cache_addr[2:0]] && (tag_m[cache_addr[2:0]] == cache_addr[13:3]);
        cache_rd_data = data_m[cache_addr[2:0]];
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) valid_m[i] <= 1'b0;
        end else if (cache_we) begin
            valid_m[cache_addr[2:0]] <= 1'b1;
            tag_m[cache_addr[2:0]]   <= cache_addr[13:3];
            data_m[cache_addr[2:0]]  <= cache_wr_data;
        end
    end

    // Memory model: each beat is presented on the 4th cycle of its request.
    int mem_cnt;
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_rdy     <= 1'b0;
            mem_rd_data <= '0;
            mem_cnt     <= 0;
        end else if (mem_rdy) begin
            mem_rdy <= 1'b0;
            mem_cnt <= mem_re ? 1 : 0;
        end else if (mem_re) begin
            if (mem_cnt == 3) begin
                mem_rdy     <= 1'b1;
                mem_rd_data <= beat_data(mem_addr);
                mem_cnt     <= 0;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    // Scoreboard queues
    logic [14:0] exp_beat[$];
    logic [13:0] exp_wr_addr[$];
    logic [63:0] exp_wr_data[$];
    logic [15:0] exp_instr[$];

    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1) begin
            if (mem_re && mem_rdy) begin
                if (exp_beat.size() == 0) chk("unexpected_beat", {49'd0, mem_addr}, 64'hDEAD);
                else chk("beat_addr", {49'd0, mem_addr}, {49'd0, exp_beat.pop_front()});
            end
            if (cache_we) begin
                if (exp_wr_addr.size() == 0) begin
                    chk("unexpected_cache_we", {50'd0, cache_addr}, 64'hDEAD);
                end else begin
                    chk("wr_addr", {50'd0, cache_addr}, {50'd0, exp_wr_addr.pop_front()});
                    chk("wr_data", cache_wr_data, exp_wr_data.pop_front());
                    chk("wr_dirty", {63'd0, cache_wdirty}, 64'd0);
                end
            end
            if (fetch_re && !stall) begin
                if (exp_instr.size() == 0) chk("unexpected_instr", {48'd0, instr}, 64'hDEAD);
                else chk("instr", {48'd0, instr}, {48'd0, exp_instr.pop_front()});
            end
        end
    end

    task automatic expect_fill(input logic [13:0] l);
        exp_beat.push_back({l, 1'b0});
        exp_beat.push_back({l, 1'b1});
        exp_wr_addr.push_back(l);
        exp_wr_data.push_back(line_data(l));
    endtask

    // Wait (bounded) until stall drops; returns number of stalled cycles.
    task automatic wait_unstall(output int n);
        n = 0;
        #3;
        while (stall && n < 50) begin
            n++;
            @(negedge clk);
            #3;
        end
    endtask

    task automatic do_fetch(input logic [15:0] a, input bit miss);
        int n;
        @(negedge clk);
        pc       = a;
        fetch_re = 1'b1;
        exp_instr.push_back(word_of(a));
        if (miss) expect_fill(a[15:2]);
        wait_unstall(n);
        chk($sformatf("stall_cycles_pc%04h", a), 64'(n), miss ? 64'd10 : 64'd0);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            fetch_re = 1'b0;
        end
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        pc       = '0;
        fetch_re = 1'b0;
        #3;
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_mem_re", {63'd0, mem_re}, 64'd0);
        chk("rst_cache_we", {63'd0, cache_we}, 64'd0);
        chk("rst_miss_cnt", {48'd0, miss_cnt}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: cold miss at pc 0
        do_fetch(16'h0000, 1'b1);
        chk("t1_miss_cnt", {48'd0, miss_cnt}, 64'd1);

        // 2: remaining words of the line hit back-to-back
        do_fetch(16'h0001, 1'b0);
        do_fetch(16'h0002, 1'b0);
        do_fetch(16'h0003, 1'b0);
        chk("t2_miss_cnt", {48'd0, miss_cnt}, 64'd1);

        // 3: same index, different tag
        idle_cycles(1);
        do_fetch(16'h0020, 1'b1);
        chk("t3_miss_cnt", {48'd0, miss_cnt}, 64'd2);

        // 4: pc/fetch_re disturbed during MEM_HI
        idle_cycles(1);
        @(negedge clk);
        pc       = 16'h0044;
        fetch_re = 1'b1;
        exp_instr.push_back(word_of(16'h0044));
        expect_fill(14'h0011);
        n = 0;
        #3;
        while (!(mem_re && mem_addr[0]) && n < 30) begin
            n++;
            @(negedge clk);
            #3;
        end
        chk("t4_reached_mem_hi", {63'd0, mem_re && mem_addr[0]}, 64'd1);
        @(negedge clk);
        pc       = 16'h1234;
        fetch_re = 1'b0;
        #3;
        chk("t4_mem_addr_hold", {49'd0, mem_addr}, 64'h23);
        chk("t4_mem_re_hold", {63'd0, mem_re}, 64'd1);
        @(negedge clk);
        pc       = 16'h0044;
        fetch_re = 1'b1;
        wait_unstall(n);
        chk("t4_unstalled", {63'd0, stall}, 64'd0);
        chk("t4_miss_cnt", {48'd0, miss_cnt}, 64'd3);

        // 5: reset during MEM_LO
        idle_cycles(1);
        @(negedge clk);
        pc       = 16'h0080;
        fetch_re = 1'b1;
        @(negedge clk);
        #3;
        chk("t5_in_mem_lo", {63'd0, mem_re}, 64'd1);
        rst_n    = 1'b0;
        fetch_re = 1'b0;
        #1;
        chk("t5_mem_re", {63'd0, mem_re}, 64'd0);
        chk("t5_stall", {63'd0, stall}, 64'd0);
        chk("t5_miss_cnt", {48'd0, miss_cnt}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(15);
        chk("t5_miss_cnt_after", {48'd0, miss_cnt}, 64'd0);

        // 6: saturation
        @(negedge clk);
        force dut.miss_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.miss_cnt_q;
        @(negedge clk);
        #3;
        chk("t6_forced", {48'd0, miss_cnt}, 64'hFFFF);
        do_fetch(16'h0100, 1'b1);
        chk("t6_saturated", {48'd0, miss_cnt}, 64'hFFFF);

        idle_cycles(3);
        chk("leftover_beats", 64'(exp_beat.size()), 64'd0);
        chk("leftover_writes", 64'(exp_wr_addr.size()), 64'd0);
        chk("leftover_instr", 64'(exp_instr.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
